// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor.
// The operands are split into BLOCK-bit slices and one slice is resolved per
// pipeline stage. Within a stage, both candidate block sums (carry-in 0 and
// carry-in 1) ripple in parallel, and the carry from the previous stage picks
// one of them. The operand bits not yet added travel down the pipeline with
// their beat. A global stall (advance) freezes every stage at once, so bubbles
// are preserved and nothing is lost or duplicated under backpressure.
module csa_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / BLOCK;

    logic             advance;
    logic [WIDTH-1:0] bbIn;
    logic             c0;

    // Ripple-carry sum of one block; result is {carry_out, sum}.
    function automatic logic [BLOCK:0] blockAdd(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             c
    );
        logic [BLOCK:0] r;
        logic           carry;
        r     = '0;
        carry = c;
        for (int i = 0; i < BLOCK; i++) begin
            r[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        r[BLOCK] = carry;
        return r;
    endfunction

    // The pipeline moves only when the output slot is empty or being drained;
    // in_ready depends on output-side state alone, never on in_valid.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Subtraction is A + ~B + 1; the external carry-in is ignored then.
    assign bbIn = sub ? ~b : b;
    assign c0   = sub | cin;

    for (genvar k = 0; k < NSTG; k++) begin : gStage
        localparam int LOW = k * BLOCK;
        localparam int REM = WIDTH - (k + 1) * BLOCK;

        logic [BLOCK-1:0]     xBlk;
        logic [BLOCK-1:0]     yBlk;
        logic                 carryIn;
        logic                 validIn;
        logic [BLOCK:0]       cand0;
        logic [BLOCK:0]       cand1;
        logic [BLOCK:0]       selSum;
        logic [LOW+BLOCK-1:0] sum_d;
        logic [LOW+BLOCK-1:0] sum_q;
        logic                 carry_q;
        logic                 valid_q;

        if (k == 0) begin : gFirst
            assign xBlk    = a[BLOCK-1:0];
            assign yBlk    = bbIn[BLOCK-1:0];
            assign carryIn = c0;
            assign validIn = in_valid;
            assign sum_d   = selSum[BLOCK-1:0];
        end else begin : gNext
            assign xBlk    = gStage[k-1].gRem.aRem_q[BLOCK-1:0];
            assign yBlk    = gStage[k-1].gRem.bRem_q[BLOCK-1:0];
            assign carryIn = gStage[k-1].carry_q;
            assign validIn = gStage[k-1].valid_q;
            assign sum_d   = {selSum[BLOCK-1:0], gStage[k-1].sum_q};
        end

        assign cand0  = blockAdd(xBlk, yBlk, 1'b0);
        assign cand1  = blockAdd(xBlk, yBlk, 1'b1);
        assign selSum = carryIn ? cand1 : cand0;

        // Register the assembled low sum bits, block carry and beat valid.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (advance) begin
                sum_q   <= sum_d;
                carry_q <= selSum[BLOCK];
                valid_q <= validIn;
            end
        end

        if (REM > 0) begin : gRem
            logic [REM-1:0] aRem_d;
            logic [REM-1:0] bRem_d;
            logic [REM-1:0] aRem_q;
            logic [REM-1:0] bRem_q;

            if (k == 0) begin : gSrcIn
                assign aRem_d = a[WIDTH-1:BLOCK];
                assign bRem_d = bbIn[WIDTH-1:BLOCK];
            end else begin : gSrcPrev
                assign aRem_d = gStage[k-1].gRem.aRem_q[REM+BLOCK-1:BLOCK];
                assign bRem_d = gStage[k-1].gRem.bRem_q[REM+BLOCK-1:BLOCK];
            end

            // Carry the not-yet-added operand bits along with their beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    aRem_q <= '0;
                    bRem_q <= '0;
                end else if (advance) begin
                    aRem_q <= aRem_d;
                    bRem_q <= bRem_d;
                end
            end
        end

        if (k == NSTG - 1) begin : gLast
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = (xBlk[BLOCK-1] == yBlk[BLOCK-1]) &
                           (selSum[BLOCK-1] != xBlk[BLOCK-1]);

            // Signed overflow is decided here, where the operand sign bits arrive.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = gStage[NSTG-1].valid_q;
    assign s         = gStage[NSTG-1].sum_q;
    assign cout      = gStage[NSTG-1].carry_q;
    assign ovf       = gStage[NSTG-1].gLast.ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Testbench for csa_pipe_adder (WIDTH=16, BLOCK=4, latency 4).
// Directed vectors come from a table of hand-computed results; a scoreboard
// fed by an arithmetic reference model checks every output transfer.
module tb_csa_pipe_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] opA;
        logic [15:0] opB;
        logic        vCin;
        logic        vSub;
        logic [15:0] expS;
        logic        expC;
        logic        expO;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int   checkCount = 0;
    int   failCount  = 0;
    res_t expQ[$];
    res_t monRes;

    csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Plain integer arithmetic: unsigned result for s/cout, signed range for ovf.
    function automatic res_t refModel(input logic [15:0] opA, input logic [15:0] opB,
                                      input logic vCin, input logic vSub);
        res_t r;
        int ua;
        int ub;
        int sa;
        int sb;
        int u;
        int sv;
        ua = int'(opA);
        ub = int'(opB);
        sa = int'($signed(opA));
        sb = int'($signed(opB));
        if (vSub) begin
            u      = ua - ub;
            sv     = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            u      = ua + ub + int'(vCin);
            sv     = sa + sb + int'(vCin);
            r.cout = (u > 65535);
        end
        r.s   = u[15:0];
        r.ovf = (sv > 32767) || (sv < -32768);
        return r;
    endfunction

    function automatic logic [15:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present one beat and hold it until the DUT accepts it.
    task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB,
                                 input logic vCin, input logic vSub);
        logic accepted;
        int   waitCycles;
        a          = opA;
        b          = opB;
        cin        = vCin;
        sub        = vSub;
        in_valid   = 1'b1;
        accepted   = 1'b0;
        waitCycles = 0;
        while (!accepted && waitCycles < 20) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            waitCycles++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1");
        end
    endtask

    // Wait for out_valid, counting cycles since the accepting edge.
    task automatic waitResult(output int lat, output logic seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            seen = out_valid;
        end
        if (!seen) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL result_timeout: out_valid stayed 0, required 1");
        end
    endtask

    // Scoreboard: push model results on accept, compare on every output transfer.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL sb_unexpected: output s=%h with no beat outstanding", s);
                end else begin
                    monRes = expQ.pop_front();
                    checkOutput("sb_s", 32'(s), 32'(monRes.s));
                    checkOutput("sb_cout", 32'(cout), 32'(monRes.cout));
                    checkOutput("sb_ovf", 32'(ovf), 32'(monRes.ovf));
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refModel(a, b, cin, sub));
            end
        end
    end

    initial begin
        vec_t        vecs[12];
        int          lat;
        logic        seen;
        logic [15:0] bpA[6];
        logic [15:0] bpB[6];
        logic        bpCin[6];
        logic        bpSub[6];
        res_t        bpExp[6];
        int          sent;
        int          got;
        int          stallLeft;
        logic        firstSeen;
        logic        accepted;
        int          staleCount;
        int          drainCycles;

        vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'h0077, 16'h0035, 1'b0, 1'b0, 16'h00AC, 1'b0, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFC1, 1'b0, 1'b0, 16'hFFC0, 1'b1, 1'b0};
        vecs[8]  = '{16'hA5A5, 16'hD2D2, 1'b0, 1'b0, 16'h7877, 1'b1, 1'b1};
        vecs[9]  = '{16'hDC6A, 16'h6A35, 1'b0, 1'b0, 16'h469F, 1'b1, 1'b0};
        vecs[10] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0};
        vecs[11] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_s", 32'(s), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed vectors, one at a time");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].opA, vecs[i].opB, vecs[i].vCin, vecs[i].vSub);
            waitResult(lat, seen);
            if (seen) begin
                checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
                checkOutput($sformatf("vec%0d_s", i), 32'(s), 32'(vecs[i].expS));
                checkOutput($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].expC));
                checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].expO));
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] back-to-back streaming");
        for (int i = 6; i < 10; i++) begin
            applyStimulus(vecs[i].opA, vecs[i].opB, vecs[i].vCin, vecs[i].vSub);
        end
        for (int i = 6; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stream%0d_s", i), 32'(s), 32'(vecs[i].expS));
            checkOutput($sformatf("stream%0d_cout", i), 32'(cout), 32'(vecs[i].expC));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("stream_drained", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] backpressure with six beats");
        for (int i = 0; i < 6; i++) begin
            bpA[i]   = pickOperand();
            bpB[i]   = pickOperand();
            bpCin[i] = 1'($urandom_range(0, 1));
            bpSub[i] = 1'($urandom_range(0, 1));
            bpExp[i] = refModel(bpA[i], bpB[i], bpCin[i], bpSub[i]);
        end
        sent      = 0;
        got       = 0;
        stallLeft = 0;
        firstSeen = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            if (sent < 6) begin
                a        = bpA[sent];
                b        = bpB[sent];
                cin      = bpCin[sent];
                sub      = bpSub[sent];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid && !firstSeen) begin
                firstSeen = 1'b1;
                stallLeft = 3;
            end
            out_ready = !(firstSeen && stallLeft > 0);
            @(negedge clk);
            if (firstSeen && stallLeft > 0) begin
                checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
                checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
                checkOutput("bp_hold_s", 32'(s), 32'(bpExp[0].s));
                checkOutput("bp_hold_cout", 32'(cout), 32'(bpExp[0].cout));
                checkOutput("bp_hold_ovf", 32'(ovf), 32'(bpExp[0].ovf));
                stallLeft--;
            end
            accepted = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("bp_order%0d_s", got), 32'(s), 32'(bpExp[got].s));
                got++;
            end
            @(posedge clk);
            #1;
            if (accepted) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_sent", 32'(sent), 32'd6);
        checkOutput("bp_received", 32'(got), 32'd6);
        @(negedge clk);
        checkOutput("bp_no_duplicate", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset with beats in flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'(16'h1111 * (i + 1)), 16'h0101, 1'b0, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_s", 32'(s), 32'd0);
        checkOutput("midreset_cout", 32'(cout), 32'd0);
        checkOutput("midreset_ovf", 32'(ovf), 32'd0);
        staleCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) staleCount++;
        end
        checkOutput("midreset_no_stale", 32'(staleCount), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0);
        waitResult(lat, seen);
        if (seen) begin
            checkOutput("post_reset_latency", 32'(lat), 32'd4);
            checkOutput("post_reset_s", 32'(s), 32'h5556);
            checkOutput("post_reset_cout", 32'(cout), 32'd0);
        end
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic with random backpressure");
        sent = 0;
        for (int cyc = 0; cyc < 600 && sent < 40; cyc++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                a        = pickOperand();
                b        = pickOperand();
                cin      = 1'($urandom_range(0, 1));
                sub      = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            accepted = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (accepted) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        drainCycles = 0;
        while (expQ.size() != 0 && drainCycles < 20) begin
            @(negedge clk);
            drainCycles++;
        end
        checkOutput("random_sent", 32'(sent), 32'd40);
        checkOutput("random_drained", 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
Parametrised, pipelined carry-select adder/subtractor. It generalises the fixed 8-bit combinational carry-select adder to WIDTH bits split into BLOCK-bit carry-select blocks, with one pipeline stage per block. A valid/ready handshake is provided on both sides, along with a subtract mode and signed-overflow output. It sits in datapaths that need a full-width adder at high clock rate with streaming throughput of one operation per cycle.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of BLOCK and at least 2*BLOCK.
BLOCK, 4, bits per carry-select block. Also the number of bits resolved per pipeline stage.
NSTG, WIDTH/BLOCK, derived value (localparam): number of pipeline stages, equal to the latency in cycles.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry in; ignored when sub=1
sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
s  out  WIDTH  sum/difference
cout  out  1  carry out of MSB; in sub mode 1 means no borrow
ovf  out  1  two's-complement signed overflow

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset: all stage valid bits cleared, so out_valid=0. s=0, cout=0, ovf=0. Reset mid-operation discards every in-flight beat; nothing is emitted afterwards.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance, with no combinational path from in_valid.
  - A beat is accepted when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - When advance=0, the whole pipeline holds and every stage register keeps its value.
  - s, cout, ovf and out_valid are stable while out_valid=1 and out_ready=0.
- Input conditioning at accept:
  - bb = sub ? ~b : b
  - c0 = sub ? 1 : cin
- Stage k (k = 0..NSTG-1), on advance:
  - Takes block k bits [k*BLOCK +: BLOCK] of a and bb, plus the carry registered by stage k-1 (c0 for k=0).
  - Computes two candidate block sums, one for carry-in 0 and one for carry-in 1, using ripple within the block.
  - Selects between them with the incoming carry.
  - Registers the selected block sum, the block carry-out, the valid bit, and the still-unprocessed upper operand bits. Upper bits are skewed: they travel down the pipeline with their beat.
- Stage NSTG-1 drives the outputs:
  - s is the full assembled sum.
  - cout is the carry out of the top block.
  - ovf = (a[W-1] == bb[W-1]) & (s[W-1] != a[W-1]). This needs the operand sign bits carried to the last stage.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+NSTG-1, provided no stall occurs. Throughput is one beat per cycle.
- Stall boundaries:
  - The pipeline is full when every stage is valid.
  - With out_ready=0 and out_valid=1, in_ready=0 and no beat is lost or duplicated.
  - Bubbles do not compress while stalled, because the stall is global.
- Results are exact mod 2^WIDTH and are identical to the behavioural expression {cout,s} = a + bb + c0.

Test Plan:
WIDTH=16, BLOCK=4, latency 4 cycles.
- Full carry chain: a=FFFF, b=FFFF, cin=0, sub=0, out_ready=1 → 4 cycles later s=FFFE, cout=1, ovf=0. Then a=FFFF, b=0000, cin=1 → s=0000, cout=1, exercising carry-select across all blocks.
- Streaming: send 0x0077+0x0035, 0xFFFF+0xFFC1, 0xA5A5+0xD2D2, 0xDC6A+0x6A35 on consecutive cycles with cin=0 → consecutive out_valid results 00AC/0, FFC0/1, 7877/1, 469F/1 (s/cout), in order, one per cycle.
- Subtract: a=0005, b=0007, sub=1 → s=FFFE, cout=0 (borrow), ovf=0. Then a=8000, b=0001, sub=1 → s=7FFF, cout=1, ovf=1.
- Signed overflow add: a=7FFF, b=0001 → s=8000, ovf=1. Then a=8000, b=8000 → s=0000, cout=1, ovf=1.
- Backpressure: stream 6 beats with out_ready held 0 after the first result appears →
  - in_ready drops the same cycle;
  - the outputs hold stable;
  - once out_ready=1, all 6 results emerge in order with none lost or duplicated.
- Reset mid-flight: accept 3 beats, then assert rst for 1 cycle → out_valid=0, s=0, cout=0, ovf=0 on the following cycle; no stale beat ever appears; a new beat returns its result after 4 cycles.
